mem_burst_master: RTL and testbench

//  Burst requester driving one port pair of the 32-bit block-RAM macro (1-cycle registered read, write bypass).

---
 rtl/mem_burst_master_pkg.sv | 15 +
 rtl/mem_burst_rdbuf.sv | 55 +++++
 rtl/mem_burst_master.sv | 159 +++++++++++++++
 tb/tb_mem_burst_master.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_master_pkg.sv
// Shared encodings for the burst master FSM and the depth of its read-return buffer.
package mem_burst_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int RDBUF_DEPTH = 2;
    localparam int RDBUF_PTR_W = $clog2(RDBUF_DEPTH);
    localparam int RDBUF_CNT_W = $clog2(RDBUF_DEPTH + 1);

endpackage

// File: rtl/mem_burst_rdbuf.sv
// Small synchronous FIFO holding read beats returned by the RAM until the consumer accepts them.
module mem_burst_rdbuf
    import mem_burst_master_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      head_data,
    output logic [RDBUF_CNT_W-1:0] count
);

    logic [DATA_W-1:0]      mem_q [RDBUF_DEPTH];
    logic [DATA_W-1:0]      mem_d [RDBUF_DEPTH];
    logic [RDBUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [RDBUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [RDBUF_CNT_W-1:0] count_q, count_d;
    logic                   pop_ok;

    assign pop_ok    = pop && (count_q != '0);
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + RDBUF_CNT_W'(push) - RDBUF_CNT_W'(pop_ok);
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + RDBUF_PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + RDBUF_PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_burst_master.sv
// Single-outstanding burst requester for one port pair of the 32-bit block RAM:
// write beats go straight to the RAM, read beats return through a 2-entry buffer with backpressure.
module mem_burst_master
    import mem_burst_master_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [31:0]      wd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    output logic             rd_last,
    output logic             done,
    output logic             ram_rden,
    output logic [WIDTH-1:0] ram_raddr,
    input  logic [31:0]      ram_rdata,
    output logic             ram_wren,
    output logic [WIDTH-1:0] ram_waddr,
    output logic [31:0]      ram_wdata
);

    localparam int OCC_W = RDBUF_CNT_W + 1;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       addr_q, addr_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       pop_cnt_q, pop_cnt_d;
    logic                   inflight_q, inflight_d;
    logic                   done_q, done_d;
    logic                   ready_en_q;

    logic [RDBUF_CNT_W-1:0] buf_count;
    logic [31:0]            buf_head;
    logic                   pop;
    logic [OCC_W-1:0]       occupancy;
    logic [OCC_W-1:0]       occ_limit;
    logic                   rden_ok;

    mem_burst_rdbuf #(
        .DATA_W (32)
    ) u_rdbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (ram_rdata),
        .pop       (pop),
        .head_data (buf_head),
        .count     (buf_count)
    );

    assign rd_valid  = (buf_count != '0);
    assign rd_data   = rd_valid ? buf_head : '0;
    assign rd_last   = rd_valid && (pop_cnt_q == len_q);
    assign pop       = rd_valid && rd_ready;
    assign cmd_ready = ready_en_q && (state_q == ST_IDLE);
    assign done      = done_q;
    assign ram_raddr = addr_q;
    assign ram_waddr = addr_q;
    assign ram_wdata = ram_wren ? wd_data : '0;

    // A new read may only be issued if its data is guaranteed a buffer slot when it lands.
    assign occupancy = {1'b0, buf_count} + OCC_W'(inflight_q);
    assign occ_limit = OCC_W'(RDBUF_DEPTH) + OCC_W'(pop);
    assign rden_ok   = (occupancy < occ_limit);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        len_d      = len_q;
        pop_cnt_d  = pop_cnt_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        wd_ready   = 1'b0;
        ram_wren   = 1'b0;
        ram_rden   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d    = cmd_addr;
                    rem_d     = cmd_len;
                    len_d     = cmd_len;
                    pop_cnt_d = '0;
                    state_d   = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                wd_ready = 1'b1;
                if (wd_valid) begin
                    ram_wren = 1'b1;
                    addr_d   = addr_q + WIDTH'(1);
                    rem_d    = rem_q - LEN_W'(1);
                    if (rem_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (rden_ok) begin
                    ram_rden   = 1'b1;
                    inflight_d = 1'b1;
                    addr_d     = addr_q + WIDTH'(1);
                    rem_d      = rem_q - LEN_W'(1);
                    if (rem_q == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && rd_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            pop_cnt_d = pop_cnt_q + LEN_W'(1);
        end
    end

    // ready_en_q keeps cmd_ready low while reset is held and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            pop_cnt_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            pop_cnt_q  <= pop_cnt_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master: a behavioural block RAM plus a word-level
// reference memory that predicts every address, data beat, RD_LAST and DONE.
module tb_mem_burst_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [9:0]  cmd_addr;
   logic [3:0]  cmd_len;
   logic        wd_valid;
   logic        wd_ready;
   logic [31:0] wd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] rd_data;
   logic        rd_last;
   logic        done;
   logic        ram_rden;
   logic [9:0]  ram_raddr;
   logic [31:0] ram_rdata;
   logic        ram_wren;
   logic [9:0]  ram_waddr;
   logic [31:0] ram_wdata;

   int testsRun;
   int failCount;

   logic [31:0] ramArray [1024];
   logic [31:0] refMem [1024];

   mem_burst_master #(
      .WIDTH (10),
      .LEN_W (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wd_valid  (wd_valid),
      .wd_ready  (wd_ready),
      .wd_data   (wd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .done      (done),
      .ram_rden  (ram_rden),
      .ram_raddr (ram_raddr),
      .ram_rdata (ram_rdata),
      .ram_wren  (ram_wren),
      .ram_waddr (ram_waddr),
      .ram_wdata (ram_wdata)
   );

   // Clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Block RAM model: registered read, write data bypassed to a same-address read.
   always @(posedge clk) begin
      if (ram_wren) ramArray[ram_waddr] <= ram_wdata;
      if (ram_rden) ram_rdata <= (ram_wren && ram_waddr == ram_raddr) ? ram_wdata : ramArray[ram_raddr];
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Every DUT output must read zero while reset is asserted.
   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
      checkOutput({tag, "_wd_ready"}, 32'(wd_ready), 32'd0);
      checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      checkOutput({tag, "_rd_data"}, rd_data, 32'd0);
      checkOutput({tag, "_rd_last"}, 32'(rd_last), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_ram_rden"}, 32'(ram_rden), 32'd0);
      checkOutput({tag, "_ram_raddr"}, 32'(ram_raddr), 32'd0);
      checkOutput({tag, "_ram_wren"}, 32'(ram_wren), 32'd0);
      checkOutput({tag, "_ram_waddr"}, 32'(ram_waddr), 32'd0);
      checkOutput({tag, "_ram_wdata"}, ram_wdata, 32'd0);
   endtask

   // Presents a command and holds it until the handshake edge; returns #1 after that edge.
   task automatic applyStimulus(input logic write, input int addr, input int len);
      int waitCycles;
      cmd_valid = 1'b1;
      cmd_write = write;
      cmd_addr  = 10'(addr);
      cmd_len   = 4'(len);
      #1;
      waitCycles = 0;
      while (!cmd_ready && waitCycles < 50) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      checkOutput("cmd_accept", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // mode: 0 = WD_VALID always high, 1 = pattern 1,0,0,1,.., 2 = random.
   task automatic runWriteBurst(input int addr, input int len, input int mode);
      logic [31:0] beatData [16];
      int beat;
      int cyc;
      for (int i = 0; i < 16; i++) beatData[i] = $urandom;
      applyStimulus(1'b1, addr, len);
      beat = 0;
      cyc  = 0;
      while (beat <= len && cyc < 200) begin
         case (mode)
            0:       wd_valid = 1'b1;
            1:       wd_valid = (cyc % 3 == 0);
            default: wd_valid = 1'($urandom_range(0, 1));
         endcase
         wd_data = beatData[beat];
         #1;
         checkOutput("wr_excl", 32'(ram_rden & ram_wren), 32'd0);
         checkOutput("wr_cmd_ready", 32'(cmd_ready), 32'd0);
         checkOutput("wr_wd_ready", 32'(wd_ready), 32'd1);
         checkOutput("wr_done_early", 32'(done), 32'd0);
         checkOutput("wr_wren", 32'(ram_wren), 32'(wd_valid));
         if (wd_valid) begin
            checkOutput("wr_waddr", 32'(ram_waddr), 32'((addr + beat) % 1024));
            checkOutput("wr_wdata", ram_wdata, beatData[beat]);
            refMem[(addr + beat) % 1024] = beatData[beat];
            beat++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      wd_valid = 1'b0;
      checkOutput("wr_beats", 32'(beat), 32'(len + 1));
      if (mode == 0) checkOutput("wr_cycles", 32'(cyc), 32'(len + 1));
      #1;
      checkOutput("wr_done", 32'(done), 32'd1);
      checkOutput("wr_idle", 32'(cmd_ready), 32'd1);
   endtask

   // mode: 0 = RD_READY always high, 1 = toggling 1,0,1,0,.., 2 = random.
   task automatic runReadBurst(input int addr, input int len, input int mode);
      int          beat;
      int          issued;
      int          cyc;
      bit          seenValid;
      bit          prevStall;
      logic [31:0] prevData;
      applyStimulus(1'b0, addr, len);
      beat      = 0;
      issued    = 0;
      cyc       = 0;
      seenValid = 1'b0;
      prevStall = 1'b0;
      prevData  = '0;
      while (beat <= len && cyc < 300) begin
         case (mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = (cyc % 2 == 0);
            default: rd_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         checkOutput("rd_excl", 32'(ram_rden & ram_wren), 32'd0);
         checkOutput("rd_cmd_ready", 32'(cmd_ready), 32'd0);
         checkOutput("rd_done_early", 32'(done), 32'd0);
         if (ram_rden) begin
            checkOutput("rd_raddr", 32'(ram_raddr), 32'((addr + issued) % 1024));
            issued++;
         end
         if (prevStall) checkOutput("rd_valid_hold", 32'(rd_valid), 32'd1);
         if (rd_valid) begin
            if (!seenValid) begin
               checkOutput("rd_latency", 32'(cyc), 32'd2);
               seenValid = 1'b1;
            end
            if (prevStall) checkOutput("rd_stable", rd_data, prevData);
            checkOutput("rd_data", rd_data, refMem[(addr + beat) % 1024]);
            checkOutput("rd_last", 32'(rd_last), 32'(beat == len));
            prevStall = !rd_ready;
            prevData  = rd_data;
            if (rd_ready) beat++;
         end else begin
            checkOutput("rd_last_idle", 32'(rd_last), 32'd0);
            prevStall = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      rd_ready = 1'b0;
      checkOutput("rd_beats", 32'(beat), 32'(len + 1));
      checkOutput("rd_issued", 32'(issued), 32'(len + 1));
      if (mode == 0) checkOutput("rd_cycles", 32'(cyc), 32'(len + 3));
      #1;
      checkOutput("rd_done", 32'(done), 32'd1);
      checkOutput("rd_idle", 32'(cmd_ready), 32'd1);
      checkOutput("rd_empty", 32'(rd_valid), 32'd0);
   endtask

   // Reset asserted partway through a long read burst, then released mid-cycle.
   task automatic runResetMidBurst();
      applyStimulus(1'b0, 32'h010, 15);
      rd_ready = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checkIdleOutputs("abort");
      @(posedge clk); #1;
      checkIdleOutputs("abort_next");
      rd_ready = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_rel_ready", 32'(cmd_ready), 32'd1);
      checkOutput("abort_rel_valid", 32'(rd_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("abort_stale_valid", 32'(rd_valid), 32'd0);
      checkOutput("abort_no_done", 32'(done), 32'd0);
   endtask

   // Bounds the whole run in case a handshake never completes.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int addr;
      int len;
      testsRun  = 0;
      failCount = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      wd_valid  = 1'b0;
      wd_data   = '0;
      rd_ready  = 1'b0;

      @(posedge clk); #1;
      checkIdleOutputs("reset");
      @(posedge clk); #3;
      rst_n = 1'b1;
      #1;
      checkOutput("rel_ready_low", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      checkOutput("rel_ready_high", 32'(cmd_ready), 32'd1);

      $display("[TB] write 4 @0x010, read back");
      runWriteBurst(32'h010, 3, 0);
      runReadBurst(32'h010, 3, 0);

      $display("[TB] 16-beat wrap at 0x3FE with stalled reads");
      runWriteBurst(32'h3FE, 15, 0);
      runReadBurst(32'h3FE, 15, 1);

      $display("[TB] write then immediate read of same word");
      runWriteBurst(32'h155, 0, 0);
      runReadBurst(32'h155, 0, 0);

      $display("[TB] write with WD_VALID gaps");
      runWriteBurst(32'h100, 5, 1);
      runReadBurst(32'h100, 5, 2);

      $display("[TB] reset during read burst");
      runResetMidBurst();
      runReadBurst(32'h010, 3, 0);

      $display("[TB] randomized bursts");
      for (int k = 0; k < 12; k++) begin
         addr = $urandom_range(0, 1023);
         len  = $urandom_range(0, 15);
         runWriteBurst(addr, len, 2);
         runReadBurst(addr, $urandom_range(0, len), 2);
      end

      @(posedge clk); #1;
      checkOutput("final_done_low", 32'(done), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
